// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell plus a borrow
// flip-flop, processing A - B LSB first under a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             En,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Dbit
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q;
    logic             bout_q;
    logic             done_q;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             b_next;
    logic [WIDTH-1:0] res_d;

    // Full-subtractor cell
    assign a_bit  = a_sr_q[0];
    assign b_bit  = b_sr_q[0];
    assign d_bit  = a_bit ^ b_bit ^ borrow_q;
    assign b_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);
    assign res_d  = {d_bit, res_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (En) begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        a_sr_q   <= A;
                        b_sr_q   <= B;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    res_q    <= res_d;
                    borrow_q <= b_next;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        // Counter never wraps arithmetically; the exit resets it.
                        cnt_q   <= '0;
                        diff_q  <= res_d;
                        bout_q  <= b_next;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy = (state_q == S_SHIFT);
    assign Dbit = (state_q == S_SHIFT) & d_bit;
    assign Done = done_q;
    assign Diff = diff_q;
    assign Bout = bout_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor; the inverse operation of the lab's combinational full adder.
- Computes DIFF = A - B one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow flip-flop.
- Uses a start/busy/done handshake so a later lab top level, or a board switch/LED wrapper, can drive it.
- Input En gates all sequential progress, matching the enable semantics of the adder cell.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..16.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- En  input  1  clock enable; when 0, all registers hold.
- Start  input  1  request; sampled only in IDLE with En=1.
- A  input  WIDTH  minuend; captured on an accepted Start.
- B  input  WIDTH  subtrahend; captured on an accepted Start.
- Busy  output  1  high while in SHIFT.
- Done  output  1  one-cycle pulse when Diff/Bout become valid.
- Diff  output  WIDTH  result A-B modulo 2^WIDTH.
- Bout  output  1  final borrow; 1 iff A < B (unsigned).
- Dbit  output  1  difference bit produced in the current SHIFT cycle (debug/LED).

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - Busy, Done, Bout, Dbit = 0; Diff = 0.
  - Operand shift registers, borrow FF and bit counter cleared.
  - Reset mid-operation aborts; no Done is produced.
- En=0: state, counter, shift registers, borrow, Diff and Bout hold. Done, if high, also holds. Stalls extend latency cycle-for-cycle.
- States: IDLE, SHIFT, DONE.
- IDLE, rising edge with En=1 and Start=1:
  - Load A and B into shift registers.
  - Borrow FF = 0, counter = 0.
  - Go to SHIFT.
  - Diff/Bout keep the previous result until overwritten.
- SHIFT, each edge with En=1, with a = A_sr[0], b = B_sr[0], bin = borrow FF:
  - d = a ^ b ^ bin.
  - bnext = (~a & b) | (~(a ^ b) & bin).
  - d shifts into the result register at the MSB (right shift); A_sr and B_sr shift right.
  - Borrow FF = bnext; counter increments.
  - On the edge where counter == WIDTH-1: Diff = completed result register, Bout = bnext, go to DONE.
- Dbit is combinational d during SHIFT, 0 otherwise.
- Busy = (state == SHIFT).
- DONE: Done=1 for exactly one enabled cycle; next enabled edge returns to IDLE.
- Start in SHIFT or DONE is ignored, never queued. Operand changes after acceptance have no effect.
- Latency: Start accepted at edge E0 → Busy high cycles E0..E(WIDTH) → Done high the cycle after edge E(WIDTH). Next Start is accepted no earlier than edge E(WIDTH+2). All counts are in En=1 edges.
- Width rules:
  - Counter is ceil(log2(WIDTH)) bits and wraps only via the state change.
  - Diff is exact modulo 2^WIDTH; Bout is the carry-out complement of A + ~B + 1.
- Start held high continuously: a new operation starts on each IDLE visit, so back-to-back results every WIDTH+2 cycles.

Test Plan:
- WIDTH=4, A=9, B=3, Start pulse, En=1 → Busy high 4 cycles; Dbit sequence LSB-first 0,1,1,0; Done pulse; Diff=6, Bout=0.
- A=3, B=9 → Diff=4'hA, Bout=1. A=0, B=0 → Diff=0, Bout=0. A=15, B=15 → Diff=0, Bout=0. A=0, B=1 → Diff=15, Bout=1.
- A=9, B=3 with En=0 for 3 cycles after the 2nd SHIFT cycle → Done arrives exactly 3 cycles later than nominal; Diff=6; Diff/Bout unchanged during the stall.
- Start re-asserted with A=1, B=1 during SHIFT of a 12-5 operation → ignored; Diff=7, Bout=0.
- rst_n low asynchronously (mid-cycle) during SHIFT → outputs 0 immediately with no Done. After release, a new 8-2 run gives Diff=6.
- Exhaustive sweep of all 256 A/B pairs at WIDTH=4 → Diff == (A-B)&15 and Bout == (A<B) on every Done.
